// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional hardwired-zero entry 0 and a sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       clear_start,
    output logic                       wr_ready,
    output logic                       clear_busy,
    output logic                       clear_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   count_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                wr_ready_r;
    logic                clear_busy_r;
    logic                clear_done_r;
    logic                wr_en_s;

    assign wr_ready   = wr_ready_r;
    assign clear_busy = clear_busy_r;
    assign clear_done = clear_done_r;

    // Next-state selection for the clear engine.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) next_state_s = ST_CLEAR;
                else             next_state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (count_r == LAST_IDX) next_state_s = ST_IDLE;
                else                     next_state_s = ST_CLEAR;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Accepted write: port free and not a dropped write to the hardwired-zero entry.
    always_comb begin
        wr_en_s = 1'b0;
        if (reg_write && wr_ready_r && !((ZERO_REG != 0) && (waddr == '0))) wr_en_s = 1'b1;
        else                                                                 wr_en_s = 1'b0;
    end

    // FSM state, clear counter and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            wr_ready_r   <= 1'b1;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            wr_ready_r   <= (next_state_s == ST_IDLE);
            clear_busy_r <= (next_state_s == ST_CLEAR);
            clear_done_r <= (state_r == ST_CLEAR) && (count_r == LAST_IDX);
            if (state_r == ST_CLEAR && count_r != LAST_IDX) count_r <= count_r + 1'b1;
            else                                            count_r <= '0;
        end
    end

    // Storage: the clear engine owns the array while busy, so writes cannot collide with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (state_r == ST_CLEAR) begin
            mem_r[count_r] <= '0;
        end else if (wr_en_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;

        assign addr_s = raddr[k*ADDR_W +: ADDR_W];

        // Combinational read; clear-engine zeroing is never forwarded, only accepted writes.
        always_comb begin
            data_s = mem_r[addr_s];
            if ((ZERO_REG != 0) && (addr_s == '0)) begin
                data_s = '0;
`ifdef REG_FILE_BYPASS_EN
            end else if (wr_en_s && (addr_s == waddr)) begin
                data_s = wdata;
`endif
            end else begin
                data_s = mem_r[addr_s];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = data_s;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default 32x32/2-port/zero-reg instance plus a
// 64-bit/4-port/no-zero-reg instance; forwarding expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file_mp;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        reg_write_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic        clear_start_a;
    logic        wr_ready_a, clear_busy_a, clear_done_a;

    logic         reg_write_b;
    logic [4:0]   waddr_b;
    logic [63:0]  wdata_b;
    logic [19:0]  raddr_b;
    logic [255:0] rdata_b;
    logic         clear_start_b;
    logic         wr_ready_b, clear_busy_b, clear_done_b;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .reg_write(reg_write_a), .waddr(waddr_a), .wdata(wdata_a),
        .raddr(raddr_a), .rdata(rdata_a), .clear_start(clear_start_a),
        .wr_ready(wr_ready_a), .clear_busy(clear_busy_a), .clear_done(clear_done_a)
    );

    reg_file_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .reg_write(reg_write_b), .waddr(waddr_b), .wdata(wdata_b),
        .raddr(raddr_b), .rdata(rdata_b), .clear_start(clear_start_b),
        .wr_ready(wr_ready_b), .clear_busy(clear_busy_b), .clear_done(clear_done_b)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_a [32];
    logic [63:0] mdl_b [32];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          busy_cnt, done_cnt, ready_bad;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [63:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [31:0] d);
        reg_write_a = 1'b1; waddr_a = a; wdata_a = d;
        tick();
        reg_write_a = 1'b0;
        if (a != 5'd0) mdl_a[a] = d;
    endtask

    task automatic write_b(input logic [4:0] a, input logic [63:0] d);
        reg_write_b = 1'b1; waddr_b = a; wdata_b = d;
        tick();
        reg_write_b = 1'b0;
        mdl_b[a] = d;
    endtask

    task automatic read_a_exp(input string tag, input logic [4:0] a0, input logic [31:0] e0,
                              input logic [4:0] a1, input logic [31:0] e1);
        raddr_a = {a1, a0};
        sb_push({tag, "_p0"}, {32'd0, e0});
        sb_push({tag, "_p1"}, {32'd0, e1});
        #1;
        sb_pop_check({32'd0, rdata_a[31:0]});
        sb_pop_check({32'd0, rdata_a[63:32]});
    endtask

    task automatic read_a(input string tag, input logic [4:0] a0, input logic [4:0] a1);
        read_a_exp(tag, a0, mdl_a[a0], a1, mdl_a[a1]);
    endtask

    task automatic read_b(input string tag, input logic [4:0] a);
        logic [4:0] ak;
        for (int k = 0; k < 4; k++) begin
            ak = a + 5'(k);
            raddr_b[k*5 +: 5] = ak;
            sb_push($sformatf("%s_p%0d", tag, k), mdl_b[ak]);
        end
        #1;
        for (int k = 0; k < 4; k++) sb_pop_check(rdata_b[k*64 +: 64]);
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin
            mdl_a[i] = 32'd0;
            mdl_b[i] = 64'd0;
        end
    endtask

    initial begin
        reset = 1'b1;
        reg_write_a = 1'b0; waddr_a = 5'd0; wdata_a = 32'd0; raddr_a = 10'd0; clear_start_a = 1'b0;
        reg_write_b = 1'b0; waddr_b = 5'd0; wdata_b = 64'd0; raddr_b = 20'd0; clear_start_b = 1'b0;
        clear_models();
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset with preloaded contents
        write_a(5'd3, 32'h11111111);
        write_a(5'd31, 32'h3131_3131);
        write_b(5'd9, 64'h9999_0000_9999_0000);
        read_a("preload", 5'd3, 5'd31);
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        clear_models();
        #1;
        check_val("rst_wr_ready", {63'd0, wr_ready_a}, 64'd1);
        check_val("rst_busy", {63'd0, clear_busy_a}, 64'd0);
        check_val("rst_done", {63'd0, clear_done_a}, 64'd0);
        for (int i = 0; i < 32; i++) read_a("rst_rd", 5'(i), 5'(31 - i));
        read_b("rst_rd_b", 5'd8);

        // Basic writes, independent and identical port addresses
        write_a(5'd31, 32'h000000FF);
        write_a(5'd1, 32'h222222FF);
        read_a("wr_rd", 5'd31, 5'd1);
        read_a("same_addr", 5'd31, 5'd31);

        // Zero register: dropped with ZERO_REG=1 (also not forwarded), stored with ZERO_REG=0
        reg_write_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hDEADBEEF;
        read_a_exp("zero_same_cyc", 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        reg_write_a = 1'b0;
        read_a_exp("zero_after", 5'd0, 32'd0, 5'd1, 32'h222222FF);
        write_b(5'd0, 64'h0000_0000_DEAD_BEEF);
        read_b("nozero_b", 5'd0);

        // Fill and clear, with a write in the start cycle and writes/restart during the clear
        for (int i = 1; i < 32; i++) write_a(5'(i), 32'hA5A5A5A5);
        busy_cnt = 0; done_cnt = 0; ready_bad = 0;
        clear_start_a = 1'b1; reg_write_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h00001234;
        tick();
        clear_start_a = 1'b0; reg_write_a = 1'b0;
        for (int c = 0; c < 100 && clear_busy_a; c++) begin
            busy_cnt++;
            if (wr_ready_a) ready_bad++;
            if (clear_done_a) done_cnt++;
            if (c == 0) read_a_exp("clr_live0", 5'd5, 32'h00001234, 5'd20, 32'hA5A5A5A5);
            if (c == 3) read_a_exp("clr_live3", 5'd2, 32'd0, 5'd3, 32'hA5A5A5A5);
            clear_start_a = (c == 10);
            reg_write_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h0000FFFF;
            tick();
        end
        reg_write_a = 1'b0; clear_start_a = 1'b0;
        check_val("clr_ready_back", {63'd0, wr_ready_a}, 64'd1);
        if (clear_done_a) done_cnt++;
        tick();
        if (clear_done_a) done_cnt++;
        tick();
        if (clear_done_a) done_cnt++;
        check_val("clr_busy_cycles", 64'(busy_cnt), 64'd32);
        check_val("clr_ready_low", 64'(ready_bad), 64'd0);
        check_val("clr_done_pulses", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 32; i++) mdl_a[i] = 32'd0;
        for (int i = 0; i < 32; i += 2) read_a("clr_all", 5'(i), 5'(i + 1));

        // Reset during a clear
        write_a(5'd4, 32'h00000044);
        write_a(5'd20, 32'h00002020);
        clear_start_a = 1'b1;
        tick();
        clear_start_a = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 100 && clear_busy_a && busy_cnt < 10; c++) begin
            busy_cnt++;
            tick();
        end
        check_val("abort_busy_seen", 64'(busy_cnt), 64'd10);
        reset = 1'b1;
        #1;
        check_val("abort_busy", {63'd0, clear_busy_a}, 64'd0);
        check_val("abort_ready", {63'd0, wr_ready_a}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            if (clear_done_a) done_cnt++;
            tick();
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (clear_done_a) done_cnt++;
            tick();
        end
        check_val("abort_no_done", 64'(done_cnt), 64'd0);
        clear_models();
        read_a("abort_rd", 5'd4, 5'd20);
        write_a(5'd6, 32'h00000066);
        read_a("abort_wr", 5'd6, 5'd4);

        // Same-cycle write and read on all four ports of the wide instance
        write_b(5'd7, 64'h0000_0000_0000_1111);
        reg_write_b = 1'b1; waddr_b = 5'd7; wdata_b = 64'h0123456789ABCDEF;
        raddr_b = {4{5'd7}};
        for (int k = 0; k < 4; k++)
            sb_push($sformatf("fwd_same_p%0d", k), BYP ? 64'h0123456789ABCDEF : 64'h1111);
        #1;
        for (int k = 0; k < 4; k++) sb_pop_check(rdata_b[k*64 +: 64]);
        tick();
        reg_write_b = 1'b0;
        mdl_b[7] = 64'h0123456789ABCDEF;
        for (int k = 0; k < 4; k++)
            sb_push($sformatf("fwd_next_p%0d", k), mdl_b[7]);
        #1;
        for (int k = 0; k < 4; k++) sb_pop_check(rdata_b[k*64 +: 64]);
        read_b("wide_mix", 5'd6);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
